// File: rtl/unidad_pc_pkg.sv
// unidad_pc_pkg: shared types and constants for the program-counter sequencer.
// Optional stack-depth guard is enabled with the macro UNIDAD_PC_GUARDA_EN.
package unidad_pc_pkg;

   localparam int ADDR_W_DEF    = 10;  // PC / stack data width
   localparam int PILA_PROF_DEF = 15;  // usable return-stack entries

   // Bit positions inside the sticky error vector
   localparam int ERR_OVF = 1;
   localparam int ERR_UNF = 0;

   typedef enum logic [1:0] {
      ARRANQUE = 2'd0,
      RUN      = 2'd1,
      PARADO   = 2'd2
   } estado_t;

endpackage

// File: rtl/unidad_pc_pc_siguiente.sv
// pc_siguiente: combinational next-PC priority mux.
// Priority: return > call > jump > conditional jump (z) > increment.
// Produces the raw push/pop requests; the top qualifies them with the FSM.
module pc_siguiente #(
   parameter int ADDR_W = 10
) (
   input  logic [ADDR_W-1:0] i_pc,
   input  logic              i_s_salto,
   input  logic              i_s_saltoc,
   input  logic              i_z,
   input  logic              i_s_call,
   input  logic              i_s_ret,
   input  logic [ADDR_W-1:0] i_dir_salto,
   input  logic [ADDR_W-1:0] i_pila_dout,
   output logic [ADDR_W-1:0] o_pc_sig,
   output logic              o_push,
   output logic              o_pop
);

   // Fixed-priority selection; lower-priority requests are simply dropped
   always_comb begin
      o_pc_sig = i_pc + ADDR_W'(1);   // wraps modulo 2^ADDR_W
      o_push   = 1'b0;
      o_pop    = 1'b0;
      if (i_s_ret) begin
         o_pc_sig = i_pila_dout;
         o_pop    = 1'b1;
      end else if (i_s_call) begin
         o_pc_sig = i_dir_salto;
         o_push   = 1'b1;
      end else if (i_s_salto) begin
         o_pc_sig = i_dir_salto;
      end else if (i_s_saltoc && i_z) begin
         o_pc_sig = i_dir_salto;
      end
   end

endmodule

// File: rtl/unidad_pc.sv
// unidad_pc: program-counter sequencer driving the return-address stack.
// FSM ARRANQUE -> RUN -> PARADO (PARADO left only by reset).
// Macro UNIDAD_PC_GUARDA_EN adds a depth counter with overflow/underflow
// detection; without it error is 00 and push/pop are always forwarded.
// push/pop are Mealy strobes valid in the cycle the request is accepted, so
// the stack and pc update on the same edge. dbg_estado exposes the FSM state.
module unidad_pc
   import unidad_pc_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int PILA_PROF = PILA_PROF_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              s_salto,
   input  logic              s_saltoc,
   input  logic              z,
   input  logic              s_call,
   input  logic              s_ret,
   input  logic              halt_req,
   input  logic [ADDR_W-1:0] dir_salto,
   input  logic [ADDR_W-1:0] pila_dout,
   output logic [ADDR_W-1:0] pc,
   output logic              pila_push,
   output logic              pila_pop,
   output logic [ADDR_W-1:0] pila_din,
   output logic              parado,
   output logic [1:0]        error,
   output logic [1:0]        dbg_estado
);

   estado_t           r_estado;
   estado_t           w_estado_sig;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_sig;
   logic              w_push_req;
   logic              w_pop_req;
   logic              w_activo;
   logic              w_fallo;

   pc_siguiente #(.ADDR_W(ADDR_W)) u_pc_siguiente (
      .i_pc        (r_pc),
      .i_s_salto   (s_salto),
      .i_s_saltoc  (s_saltoc),
      .i_z         (z),
      .i_s_call    (s_call),
      .i_s_ret     (s_ret),
      .i_dir_salto (dir_salto),
      .i_pila_dout (pila_dout),
      .o_pc_sig    (w_pc_sig),
      .o_push      (w_push_req),
      .o_pop       (w_pop_req)
   );

   // A cycle performs a control action only in RUN, not stalled, not halting
   // and not under reset.
   assign w_activo = (r_estado == RUN) && !stall && !halt_req && !reset;

`ifdef UNIDAD_PC_GUARDA_EN
   localparam int PROF_W = $clog2(PILA_PROF + 1);

   logic [PROF_W-1:0] r_prof;
   logic [1:0]        r_error;
   logic              w_ovf;
   logic              w_unf;

   assign w_ovf   = w_activo && w_push_req && (r_prof == PROF_W'(PILA_PROF));
   assign w_unf   = w_activo && w_pop_req  && (r_prof == '0);
   assign w_fallo = w_ovf || w_unf;

   // Stack depth follows the accepted push/pop strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prof <= '0;
      end else if (pila_push) begin
         r_prof <= r_prof + PROF_W'(1);
      end else if (pila_pop) begin
         r_prof <= r_prof - PROF_W'(1);
      end
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_error <= 2'b00;
      end else begin
         if (w_ovf) r_error[ERR_OVF] <= 1'b1;
         if (w_unf) r_error[ERR_UNF] <= 1'b1;
      end
   end

   assign error = r_error;
`else
   assign w_fallo = 1'b0;
   assign error   = 2'b00;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_estado <= ARRANQUE;
      end else begin
         r_estado <= w_estado_sig;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_estado_sig = r_estado;
      case (r_estado)
         ARRANQUE: w_estado_sig = RUN;
         RUN: begin
            if (!stall && (halt_req || w_fallo)) begin
               w_estado_sig = PARADO;
            end
         end
         PARADO:   w_estado_sig = PARADO;
         default:  w_estado_sig = ARRANQUE;
      endcase
   end

   // FSM outputs: qualified stack strobes and status
   always_comb begin
      pila_push  = w_activo && w_push_req && !w_fallo;
      pila_pop   = w_activo && w_pop_req  && !w_fallo;
      parado     = (r_estado == PARADO);
      dbg_estado = r_estado;
   end

   // Program counter: advances only on an accepted, fault-free cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc <= '0;
      end else if (w_activo && !w_fallo) begin
         r_pc <= w_pc_sig;
      end
   end

   assign pc       = r_pc;
   assign pila_din = r_pc;

endmodule

// File: tb/tb_unidad_pc.sv
// tb_unidad_pc: directed scoreboard bench for unidad_pc.
// Build with or without UNIDAD_PC_GUARDA_EN; the depth-guard section adapts.
module tb_unidad_pc;

   localparam int W = 10;
   localparam int E = 25;  // {pc, push, pop, din, parado, error}

   logic          clk = 1'b0;
   logic          reset, stall, s_salto, s_saltoc, z, s_call, s_ret, halt_req;
   logic [W-1:0]  dir_salto, pila_dout;
   logic [W-1:0]  pc, pila_din;
   logic          pila_push, pila_pop, parado;
   logic [1:0]    error, dbg_estado;

   logic [E-1:0]  exp_q[$];
   int            n_chk  = 0;
   int            n_fail = 0;
   int            n_cyc  = 0;

   unidad_pc dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .s_salto    (s_salto),
      .s_saltoc   (s_saltoc),
      .z          (z),
      .s_call     (s_call),
      .s_ret      (s_ret),
      .halt_req   (halt_req),
      .dir_salto  (dir_salto),
      .pila_dout  (pila_dout),
      .pc         (pc),
      .pila_push  (pila_push),
      .pila_pop   (pila_pop),
      .pila_din   (pila_din),
      .parado     (parado),
      .error      (error),
      .dbg_estado (dbg_estado)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // driver: apply one cycle of inputs and queue the expected outputs
   task automatic paso(input logic rst, input logic st, input logic sa,
                       input logic sc, input logic zz, input logic ca,
                       input logic re, input logic ha,
                       input logic [W-1:0] dir, input logic [W-1:0] pd,
                       input logic [W-1:0] e_pc, input logic e_push,
                       input logic e_pop, input logic e_par,
                       input logic [1:0] e_err);
      reset     = rst;
      stall     = st;
      s_salto   = sa;
      s_saltoc  = sc;
      z         = zz;
      s_call    = ca;
      s_ret     = re;
      halt_req  = ha;
      dir_salto = dir;
      pila_dout = pd;
      exp_q.push_back({e_pc, e_push, e_pop, e_pc, e_par, e_err});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [W-1:0] e_pc, input logic e_par,
                       input logic [1:0] e_err);
      paso(0,0,0,0,0,0,0,0, 10'd0, 10'd0, e_pc, 0, 0, e_par, e_err);
   endtask

   task automatic chk(input string nombre, input logic [W-1:0] act,
                      input logic [W-1:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nombre, n_cyc, act, req);
      end
   endtask

   // scoreboard monitor: compare mid-cycle, away from the active edge
   always @(negedge clk) begin
      logic [E-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cyc++;
         chk("pc",        pc,                   e[24:15]);
         chk("pila_push", W'(pila_push),        W'(e[14]));
         chk("pila_pop",  W'(pila_pop),         W'(e[13]));
         chk("pila_din",  pila_din,             e[12:3]);
         chk("parado",    W'(parado),           W'(e[2]));
         chk("error",     W'(error),            W'(e[1:0]));
      end
   end

   initial begin
      reset = 1'b1; stall = 0; s_salto = 0; s_saltoc = 0; z = 0;
      s_call = 0; s_ret = 0; halt_req = 0; dir_salto = '0; pila_dout = '0;
      @(posedge clk);
      #1;
      // reset held: pc 0, no strobes
      paso(1,0,0,0,0,0,0,0, 10'd0, 10'd0, 10'd0, 0,0,0, 2'b00);
      paso(1,0,0,0,0,1,0,0, 10'd9, 10'd0, 10'd0, 0,0,0, 2'b00);
      // ARRANQUE holds 0, then increment
      idle(10'd0, 0, 2'b00);
      idle(10'd0, 0, 2'b00);
      idle(10'd1, 0, 2'b00);
      idle(10'd2, 0, 2'b00);
      idle(10'd3, 0, 2'b00);
      idle(10'd4, 0, 2'b00);
      // call at pc=5 to 100, then return to 6
      paso(0,0,0,0,0,1,0,0, 10'd100, 10'd0, 10'd5,   1,0,0, 2'b00);
      paso(0,0,0,0,0,0,1,0, 10'd0,   10'd6, 10'd100, 0,1,0, 2'b00);
      // conditional jump not taken, then taken
      paso(0,0,0,1,0,0,0,0, 10'd40, 10'd0, 10'd6, 0,0,0, 2'b00);
      paso(0,0,0,1,1,0,0,0, 10'd40, 10'd0, 10'd7, 0,0,0, 2'b00);
      // ret + call + salto together: return wins, pop only
      paso(0,0,1,0,0,1,1,0, 10'd200, 10'd9, 10'd40, 0,1,0, 2'b00);
      // jump to 1023, call there pushes 1023
      paso(0,0,1,0,0,0,0,0, 10'd1023, 10'd0, 10'd9,    0,0,0, 2'b00);
      paso(0,0,0,0,0,1,0,0, 10'd50,   10'd0, 10'd1023, 1,0,0, 2'b00);
      paso(0,0,0,0,0,0,1,0, 10'd0,    10'd0, 10'd50,   0,1,0, 2'b00);
      // stall with call for 3 cycles
      for (int i = 0; i < 3; i++)
         paso(0,1,0,0,0,1,0,0, 10'd500, 10'd0, 10'd0, 0,0,0, 2'b00);
      // wrap 1023 -> 0
      paso(0,0,1,0,0,0,0,0, 10'd1023, 10'd0, 10'd0, 0,0,0, 2'b00);
      idle(10'd1023, 0, 2'b00);
      paso(0,0,1,0,0,0,0,0, 10'd12, 10'd0, 10'd0, 0,0,0, 2'b00);
      // halt at pc=12 despite jump
      paso(0,0,1,0,0,0,0,1, 10'd300, 10'd0, 10'd12, 0,0,0, 2'b00);
      paso(0,0,1,0,0,1,0,0, 10'd300, 10'd0, 10'd12, 0,0,1, 2'b00);
      paso(0,0,0,0,0,0,1,0, 10'd0,   10'd7, 10'd12, 0,0,1, 2'b00);
      // reset from PARADO
      paso(1,0,0,0,0,0,0,0, 10'd0, 10'd0, 10'd12, 0,0,1, 2'b00);
      idle(10'd0, 0, 2'b00);
      // reset mid-call in RUN: no push
      paso(1,0,0,0,0,1,0,0, 10'd77, 10'd0, 10'd0, 0,0,0, 2'b00);
      idle(10'd0, 0, 2'b00);
      idle(10'd0, 0, 2'b00);
      // 16 calls from depth 0
      for (int k = 0; k < 16; k++) begin
`ifdef UNIDAD_PC_GUARDA_EN
         paso(0,0,0,0,0,1,0,0, 10'd100, 10'd0, (k == 0) ? 10'd1 : 10'd100,
              (k < 15), 0, 0, 2'b00);
`else
         paso(0,0,0,0,0,1,0,0, 10'd100, 10'd0, (k == 0) ? 10'd1 : 10'd100,
              1, 0, 0, 2'b00);
`endif
      end
`ifdef UNIDAD_PC_GUARDA_EN
      idle(10'd100, 1, 2'b10);
      paso(1,0,0,0,0,0,0,0, 10'd0, 10'd0, 10'd100, 0,0,1, 2'b10);
      idle(10'd0, 0, 2'b00);
      paso(0,0,0,0,0,0,1,0, 10'd0, 10'd33, 10'd0, 0,0,0, 2'b00);
      idle(10'd0, 1, 2'b01);
`else
      paso(0,0,0,0,0,0,1,0, 10'd0, 10'd33, 10'd100, 0,1,0, 2'b00);
      idle(10'd33, 0, 2'b00);
`endif
      idle(pc_after_end(), parado_after_end(), err_after_end());
      // drain the scoreboard with a bounded wait
      for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // expected state of the final idle cycle for each build
   function automatic logic [W-1:0] pc_after_end();
`ifdef UNIDAD_PC_GUARDA_EN
      return 10'd0;
`else
      return 10'd34;
`endif
   endfunction

   function automatic logic parado_after_end();
`ifdef UNIDAD_PC_GUARDA_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [1:0] err_after_end();
`ifdef UNIDAD_PC_GUARDA_EN
      return 2'b01;
`else
      return 2'b00;
`endif
   endfunction

endmodule
